// File: rtl/edge_packer.sv
// Binarizes a gradient stream against an adaptive per-frame threshold, packs edge
// bits MSB-first into bytes, and reports per-frame edge count and frame completion.
module edge_packer #(
  parameter int unsigned GRAD_WIDTH   = 11,
  parameter int unsigned FRAME_PIXELS = 64516,
  parameter int unsigned THRESH_SHIFT = 2,
  parameter int unsigned INIT_THRESH  = 200,
  parameter int unsigned EC_W         = $clog2(FRAME_PIXELS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gradient_valid,
  input  logic [GRAD_WIDTH-1:0] gradient,
  output logic [7:0]            edge_byte,
  output logic                  edge_byte_valid,
  output logic                  frame_done,
  output logic [EC_W-1:0]       edge_count,
  output logic [GRAD_WIDTH-1:0] threshold
);

  localparam int unsigned         PC_W     = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [PC_W-1:0]     LAST_PIX = PC_W'(FRAME_PIXELS - 1);
  localparam logic [GRAD_WIDTH-1:0] THR_RST  = GRAD_WIDTH'(INIT_THRESH);
  localparam logic [GRAD_WIDTH-1:0] THR_MIN  = GRAD_WIDTH'(1);

  typedef enum logic {
    S_RUN = 1'b0,
    S_END = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shreg_q, shreg_d;
  logic [PC_W-1:0]       pix_cnt_q, pix_cnt_d;
  logic [EC_W-1:0]       count_q, count_d;
  logic [GRAD_WIDTH-1:0] peak_q, peak_d;
  logic [7:0]            edge_byte_q, edge_byte_d;
  logic                  edge_byte_valid_q, edge_byte_valid_d;
  logic [EC_W-1:0]       edge_count_q, edge_count_d;
  logic [GRAD_WIDTH-1:0] threshold_q, threshold_d;

  logic                  edge_bit_c;
  logic                  last_pix_c;
  logic                  byte_done_c;
  logic [7:0]            shreg_next_c;
  logic [EC_W-1:0]       count_inc_c;
  logic [GRAD_WIDTH-1:0] peak_next_c;
  logic [GRAD_WIDTH-1:0] peak_scaled_c;

  // Per-pixel datapath terms, valid only when gradient_valid is high.
  always_comb begin
    edge_bit_c    = (gradient > threshold_q);
    shreg_next_c  = edge_bit_c ? (shreg_q | (8'h80 >> bit_idx_q)) : shreg_q;
    last_pix_c    = gradient_valid && (pix_cnt_q == LAST_PIX);
    byte_done_c   = gradient_valid && ((bit_idx_q == 3'd7) || last_pix_c);
    count_inc_c   = count_q + EC_W'(edge_bit_c);
    peak_next_c   = (gradient > peak_q) ? gradient : peak_q;
    peak_scaled_c = peak_next_c >> THRESH_SHIFT;
  end

  // Next-state and output logic; the END state carries the frame_done pulse.
  always_comb begin
    state_d           = S_RUN;
    bit_idx_d         = bit_idx_q;
    shreg_d           = shreg_q;
    pix_cnt_d         = pix_cnt_q;
    count_d           = count_q;
    peak_d            = peak_q;
    edge_byte_d       = edge_byte_q;
    edge_byte_valid_d = 1'b0;
    edge_count_d      = edge_count_q;
    threshold_d       = threshold_q;

    if (gradient_valid) begin
      count_d   = count_inc_c;
      peak_d    = peak_next_c;
      pix_cnt_d = pix_cnt_q + PC_W'(1);
      if (byte_done_c) begin
        edge_byte_d       = shreg_next_c;
        edge_byte_valid_d = 1'b1;
        shreg_d           = 8'h00;
        bit_idx_d         = 3'd0;
      end else begin
        shreg_d   = shreg_next_c;
        bit_idx_d = bit_idx_q + 3'd1;
      end
      // Frame end: publish stats, adapt threshold (floored at 1), restart counters.
      if (last_pix_c) begin
        state_d      = S_END;
        edge_count_d = count_inc_c;
        threshold_d  = (peak_scaled_c == '0) ? THR_MIN : peak_scaled_c;
        count_d      = '0;
        peak_d       = '0;
        pix_cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_RUN;
      bit_idx_q         <= 3'd0;
      shreg_q           <= 8'h00;
      pix_cnt_q         <= '0;
      count_q           <= '0;
      peak_q            <= '0;
      edge_byte_q       <= 8'h00;
      edge_byte_valid_q <= 1'b0;
      edge_count_q      <= '0;
      threshold_q       <= THR_RST;
    end else begin
      state_q           <= state_d;
      bit_idx_q         <= bit_idx_d;
      shreg_q           <= shreg_d;
      pix_cnt_q         <= pix_cnt_d;
      count_q           <= count_d;
      peak_q            <= peak_d;
      edge_byte_q       <= edge_byte_d;
      edge_byte_valid_q <= edge_byte_valid_d;
      edge_count_q      <= edge_count_d;
      threshold_q       <= threshold_d;
    end
  end

  assign edge_byte       = edge_byte_q;
  assign edge_byte_valid = edge_byte_valid_q;
  assign frame_done      = (state_q == S_END);
  assign edge_count      = edge_count_q;
  assign threshold       = threshold_q;

endmodule

// File: tb/tb_edge_packer.sv
// Randomized scoreboard bench for edge_packer: a frame-level model predicts bytes
// and per-frame statistics; a negedge monitor checks every DUT pulse against them.
module tb_edge_packer;

  localparam int GW   = 11;
  localparam int FP   = 12;
  localparam int SH   = 1;
  localparam int INIT = 100;
  localparam int ECW  = $clog2(FP + 1);
  localparam int GMAX = (1 << GW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           gradient_valid = 1'b0;
  logic [GW-1:0]  gradient = '0;
  logic [7:0]     edge_byte;
  logic           edge_byte_valid;
  logic           frame_done;
  logic [ECW-1:0] edge_count;
  logic [GW-1:0]  threshold;

  edge_packer #(
    .GRAD_WIDTH  (GW),
    .FRAME_PIXELS(FP),
    .THRESH_SHIFT(SH),
    .INIT_THRESH (INIT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .gradient_valid (gradient_valid),
    .gradient       (gradient),
    .edge_byte      (edge_byte),
    .edge_byte_valid(edge_byte_valid),
    .frame_done     (frame_done),
    .edge_count     (edge_count),
    .threshold      (threshold)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected pulses: {last_of_frame, byte}, and per-frame statistics.
  logic [8:0] exp_byte[$];
  int         exp_cnt[$];
  int         exp_thr[$];

  // Reference model state: bits of the current group and frame-level totals.
  bit m_bits[$];
  int m_thr  = INIT;
  int m_cnt  = 0;
  int m_peak = 0;
  int m_npix = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_thr  = INIT;
    m_cnt  = 0;
    m_peak = 0;
    m_npix = 0;
  endtask

  task automatic send(input int g);
    logic [7:0] b;
    bit         last;
    @(negedge clk);
    gradient_valid = 1'b1;
    gradient       = GW'(g);
    m_bits.push_back(g > m_thr);
    if (g > m_thr) m_cnt++;
    if (g > m_peak) m_peak = g;
    m_npix++;
    last = (m_npix == FP);
    if (m_bits.size() == 8 || last) begin
      b = 8'h00;
      for (int i = 0; i < m_bits.size(); i++) b[7-i] = m_bits[i];
      exp_byte.push_back({last, b});
      m_bits.delete();
    end
    if (last) begin
      m_thr = (m_peak >> SH) < 1 ? 1 : (m_peak >> SH);
      exp_cnt.push_back(m_cnt);
      exp_thr.push_back(m_thr);
      m_cnt  = 0;
      m_peak = 0;
      m_npix = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      gradient_valid = 1'b0;
      gradient       = GW'($urandom_range(0, GMAX));
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (n) begin
      gradient_valid = 1'($urandom_range(0, 1));
      gradient       = GW'($urandom_range(0, GMAX));
      @(negedge clk);
    end
    chk("rst_edge_byte", int'(edge_byte), 0);
    chk("rst_byte_valid", int'(edge_byte_valid), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_edge_count", int'(edge_count), 0);
    chk("rst_threshold", int'(threshold), INIT);
    rst            = 1'b0;
    gradient_valid = 1'b0;
  endtask

  function automatic int pick_grad();
    int r;
    r = $urandom_range(0, 4);
    case (r)
      0:       return m_thr;
      1:       return (m_thr + 1 > GMAX) ? GMAX : m_thr + 1;
      2:       return $urandom_range(0, 8);
      default: return $urandom_range(0, GMAX);
    endcase
  endfunction

  // Monitor: every pulse must match the head of the expectation queues.
  always @(negedge clk) begin
    logic [8:0] e;
    if (edge_byte_valid) begin
      if (exp_byte.size() == 0) begin
        chk("unexpected_byte_pulse", int'(edge_byte), -1);
      end else begin
        e = exp_byte.pop_front();
        chk("edge_byte", int'(edge_byte), int'(e[7:0]));
        chk("frame_done_with_byte", int'(frame_done), int'(e[8]));
      end
    end else if (frame_done) begin
      chk("frame_done_without_byte", int'(edge_byte_valid), 1);
    end
    if (frame_done) begin
      if (exp_cnt.size() == 0) begin
        chk("unexpected_frame_done", int'(frame_done), 0);
      end else begin
        chk("edge_count", int'(edge_count), exp_cnt.pop_front());
        chk("threshold_new", int'(threshold), exp_thr.pop_front());
      end
    end
  end

  initial begin
    int pat[8];
    pat = '{101, 100, 101, 100, 101, 100, 101, 100};

    do_reset(10);

    // 8 consecutive pixels then 4 more to close the frame.
    foreach (pat[i]) send(pat[i]);
    send(2047); send(0); send(0); send(2047);
    idle(1);
    chk("f1_frame_done", int'(frame_done), 1);
    chk("f1_edge_byte", int'(edge_byte), 8'h90);
    chk("f1_edge_count", int'(edge_count), 6);
    chk("f1_threshold", int'(threshold), 1023);

    // Next frame: 1023 is not above threshold, 1024 is.
    send(1023); send(1024);
    for (int i = 0; i < FP - 2; i++) send(pick_grad());
    idle(2);

    // Same pattern with valid toggling every other cycle.
    do_reset(3);
    foreach (pat[i]) begin send(pat[i]); idle(1); end
    idle(3);

    // Reset after 5 accepted pixels, then a clean frame.
    do_reset(2);
    for (int i = 0; i < 5; i++) send(pick_grad());
    do_reset(2);
    for (int i = 0; i < FP; i++) send(pick_grad());
    idle(1);

    // All-zero frame drives the threshold to its floor.
    for (int i = 0; i < FP; i++) send(0);
    idle(1);
    chk("zero_edge_count", int'(edge_count), 0);
    chk("zero_threshold", int'(threshold), 1);
    idle(2);

    // Random frames, back-to-back or with idles, one mid-frame reset.
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < FP; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        if (f == 7 && i == 6) do_reset(1);
        send(pick_grad());
      end
    end
    idle(4);

    chk("bytes_drained", exp_byte.size(), 0);
    chk("frames_drained", exp_cnt.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/edge_packer.md
# edge_packer

Downstream stage of `sobel_filter`: consumes the `gradient`/`gradient_valid` stream and binarizes each gradient against an adaptive per-frame threshold. It packs the edge bits MSB-first into bytes for the result writer. It also reports a per-frame edge-pixel count and a frame-done pulse. The threshold for frame N+1 is derived from the peak gradient of frame N.

## Interface
- `GRAD_WIDTH`, 11, gradient width; matches `sobel_filter` output.
- `FRAME_PIXELS`, 64516, valid gradients per frame (254×254 interior of a 256×256 image).
- `THRESH_SHIFT`, 2, next threshold = frame peak >> `THRESH_SHIFT`.
- `INIT_THRESH`, 200, threshold after reset; used for the first frame.
- `EC_W`, `$clog2(FRAME_PIXELS+1)`, derived width of `edge_count`.
- Clocking: one clock, `clk`. Reset `rst` is synchronous and active-high.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous active-high reset.
- `gradient_valid`  in  1  qualifies `gradient` for this cycle.
- `gradient`  in  `GRAD_WIDTH`  unsigned gradient magnitude.
- `edge_byte`  out  8  packed edge bits; first pixel of the group is in bit 7.
- `edge_byte_valid`  out  1  one-cycle pulse; `edge_byte` is valid this cycle.
- `frame_done`  out  1  one-cycle pulse following the last pixel of a frame.
- `edge_count`  out  `EC_W`  edge pixels in the last completed frame; held until the next `frame_done`.
- `threshold`  out  `GRAD_WIDTH`  threshold currently applied.

## Operation
- Edge bit = (`gradient` > `threshold`), unsigned and strict; equal to the threshold gives 0.
- A pixel is accepted only on a rising edge with `gradient_valid`=1. Idle cycles change no state and are allowed anywhere.
- Bit packing:
  - A 3-bit slot counter `bit_idx` places each accepted bit at position 7−`bit_idx`.
  - On the 8th bit, the byte is registered to `edge_byte`, the shift register is cleared, and `bit_idx` wraps to 0.
- Pixel counter `pix_cnt` (0..`FRAME_PIXELS`−1):
  - Increments per accepted pixel.
  - When the pixel with `pix_cnt`=`FRAME_PIXELS`−1 is accepted, the frame ends.
- Frame end, all in one edge:
  - The partial byte (if any) is flushed with the unfilled LSBs zero. If the last pixel also completes a full byte, exactly one byte is emitted.
  - `frame_done` is pulsed.
  - `edge_count` ← running count including the last pixel.
  - `threshold` ← max(peak >> `THRESH_SHIFT`, 1), where peak includes the last pixel.
  - Running count, peak, `pix_cnt` and `bit_idx` are cleared.
- The running peak register is `GRAD_WIDTH` wide and updates to `gradient` when larger.
- The running count is `EC_W` wide; overflow is not possible by construction.
- Two-state control:
  - RUN: accepting pixels.
  - END: a one-cycle registered state in which the output pulses are asserted.
  - A pixel accepted during END belongs to the new frame and is processed normally, so back-to-back frames need no gap.

## Timing
- Reset values: `edge_byte`=0, `edge_byte_valid`=0, `frame_done`=0, `edge_count`=0, `threshold`=`INIT_THRESH`.
- Reset also clears the internal count, peak, `pix_cnt` and `bit_idx`.
- All outputs are registered. Latency is 1 cycle: `edge_byte_valid` is high in the cycle after the edge that accepted the 8th bit, or the frame's last pixel.
- `frame_done` and the flushed `edge_byte_valid` are asserted in the same cycle.
- The new `edge_count` and `threshold` are visible in that same cycle. The new `threshold` applies to the first pixel of the next frame and to no pixel of the finishing frame.
- `edge_byte` holds its value between pulses.
- `rst` mid-frame:
  - Takes effect at the next edge regardless of `gradient_valid`.
  - The partial byte is discarded with no flush pulse.
  - `threshold` returns to `INIT_THRESH`.
- No backpressure: the consumer must accept every pulse.

## Test plan
Parameters for all scenarios: `FRAME_PIXELS`=12, `THRESH_SHIFT`=1, `INIT_THRESH`=100.
- Reset: hold `rst` 10 cycles -> all outputs 0, `threshold`=100, no pulses.
- 8 consecutive valid gradients 101,100,101,100,101,100,101,100 -> `edge_byte`=0xAA, `edge_byte_valid` high for exactly 1 cycle, one cycle after the 8th.
- Same 8 values with `gradient_valid` toggling every other cycle -> single `edge_byte`=0xAA, one cycle after the 8th accepted pixel; no extra pulses.
- Full frame: the 8 above plus 2047,0,0,2047 ->
  - 0xAA, then `edge_byte`=0x90 with `frame_done` in the same cycle.
  - `edge_count`=6, `threshold`=1023.
  - Next frame: pixel 1023 gives bit 0; pixel 1024 gives bit 1.
- Reset after 5 accepted pixels -> no `edge_byte_valid`, `threshold`=100. A following 12-pixel frame produces correct bytes from bit 7.
- All-zero frame -> bytes 0x00, 0x00; `edge_count`=0; `threshold`=1 (floor).
